wb_merge_queue: RTL

- Writeback merge stage directly upstream of the register file in the dual-issue core.
- Accepts up to two writeback results per cycle (lane 0 and lane 1) into an in-order queue.
- Drains one entry per cycle onto the register file's single write port (write enable, write address, write data).
- Forwards queued-but-uncommitted values to the two register-read addresses, so decode reads see the youngest pending value.

---
 rtl/wb_merge_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_merge_queue.sv
// Writeback merge queue: collects up to two writeback results per cycle in
// program order, drains one per cycle into the register file's single write
// port, and forwards pending (not yet committed) values to the two decode
// read addresses.
module wb_merge_queue #(
  parameter int DEPTH   = 4,
  parameter int DROP_X0 = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb0_valid,
  input  logic [4:0]                 wb0_rd,
  input  logic [31:0]                wb0_data,
  input  logic                       wb1_valid,
  input  logic [4:0]                 wb1_rd,
  input  logic [31:0]                wb1_data,
  output logic                       wb_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_wa,
  output logic [31:0]                rf_wd,
  input  logic [4:0]                 rd_addr1,
  input  logic [4:0]                 rd_addr2,
  output logic                       fwd_hit1,
  output logic [31:0]                fwd_data1,
  output logic                       fwd_hit2,
  output logic [31:0]                fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Entry storage; occupancy is tracked by head/count, so no per-entry valid.
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          acc0, acc1, deq;
  logic [PW-1:0] wr1_idx;
  logic          fwd_en1, fwd_en2;

  // A lane is enqueue-worthy when valid, unless it targets x0 and x0 writes are dropped.
  function automatic logic lane_ok(input logic v, input logic [4:0] rd);
    return v && !((DROP_X0 != 0) && (rd == 5'd0));
  endfunction

  // Space for two entries is required so a dual-issue pair is never split.
  assign wb_ready = (count_q <= CW'(DEPTH - 2));
  assign acc0     = wb_ready && lane_ok(wb0_valid, wb0_rd);
  assign acc1     = wb_ready && lane_ok(wb1_valid, wb1_rd);
  assign deq      = (count_q != '0);
  // Lane 1 lands right behind lane 0, or at tail when lane 0 is not accepted.
  assign wr1_idx  = tail_q + PW'(acc0);

  assign rf_we    = deq;
  assign rf_wa    = rd_q[head_q];
  assign rf_wd    = data_q[head_q];
  assign count    = count_q;

  assign fwd_en1  = !((DROP_X0 != 0) && (rd_addr1 == 5'd0));
  assign fwd_en2  = !((DROP_X0 != 0) && (rd_addr2 == 5'd0));

  // Next-state for pointers and occupancy: accept 0..2, drain 1 whenever non-empty.
  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(acc0) + PW'(acc1);
    count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(deq);
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload write, lane 0 first then lane 1 in program order.
  always_ff @(posedge clk) begin
    if (acc0) begin
      rd_q[tail_q]   <= wb0_rd;
      data_q[tail_q] <= wb0_data;
    end
    if (acc1) begin
      rd_q[wr1_idx]   <= wb1_rd;
      data_q[wr1_idx] <= wb1_data;
    end
  end

  // Forwarding search oldest-to-youngest so the youngest match wins.
  always_comb begin : fwd_search
    logic [PW-1:0] slot;
    slot      = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (fwd_en1 && (rd_q[slot] == rd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[slot];
        end
        if (fwd_en2 && (rd_q[slot] == rd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[slot];
        end
      end
    end
  end

endmodule
